// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM blocks: mode encodings, default
// timing for a 100 MHz clock, and the position clamp helper.
package servo_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_TRACK = 2'b01,
        MODE_SWEEP = 2'b10
    } mode_e;

    localparam int CLK_HZ           = 100_000_000;
    localparam int TICK_US          = 10;
    localparam int DEF_TICK_DIV     = (CLK_HZ / 1_000_000) * TICK_US;
    localparam int DEF_PERIOD_TICKS = 20_000 / TICK_US;
    localparam int DEF_MIN_TICKS    = 1_000 / TICK_US;

    function automatic int unsigned clamp_pos(input int unsigned pos, input int unsigned span);
        return (pos > span) ? span : pos;
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// One-clk tick enable every TICK_DIV clocks, from a free-running divider.
module servo_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_en
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick_en = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cnt <= '0;
        else if (tick_en) cnt <= '0;
        else              cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared tick/frame timing, per-channel mode,
// target and slew, with all channel state changes applied at frame boundaries.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int SPAN         = 100,
    parameter int STEP         = 1,
    parameter int NUM_CH       = 4,
    parameter int POS_W        = 8,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [1:0]        cmd_mode,
    input  logic [POS_W-1:0]  cmd_pos,
    output logic [NUM_CH-1:0] servo,
    output logic              frame_start,
    output logic [NUM_CH-1:0] busy,
    output logic              cmd_err
);

    localparam int FW = $clog2(PERIOD_TICKS);
    localparam int PW = POS_W + 1;
    localparam logic [PW-1:0]   STEP_X   = PW'(STEP);
    localparam logic [PW-1:0]   SPAN_X   = PW'(SPAN);
    localparam logic [CH_W:0]   NUM_CH_X = (CH_W + 1)'(NUM_CH);

    logic          tick_en;
    logic [FW-1:0] fcnt;
    logic          boundary;
    logic          cmd_acc;
    logic          ch_bad;
    mode_e         cmd_mode_m;
    logic [POS_W-1:0] pos_cl;

    servo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick_en (tick_en)
    );

    assign boundary    = tick_en && (fcnt == FW'(PERIOD_TICKS - 1));
    assign frame_start = boundary;
    // Commands are refused only in the boundary clk, so a write never races the update.
    assign cmd_ready   = !boundary;
    assign cmd_acc     = cmd_valid && cmd_ready;
    assign ch_bad      = ({1'b0, cmd_ch} >= NUM_CH_X);
    assign cmd_mode_m  = (cmd_mode == MODE_TRACK || cmd_mode == MODE_SWEEP) ? mode_e'(cmd_mode) : MODE_OFF;
    assign pos_cl      = POS_W'(clamp_pos(32'(cmd_pos), SPAN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt    <= '0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_acc && ch_bad;
            if (tick_en) fcnt <= boundary ? '0 : fcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_e            mode_q, pend_q;
        logic [POS_W-1:0] cur_q, tgt_q;
        logic             dir_up_q, busy_q, servo_q;
        logic [PW-1:0]    cur_x, tgt_x, cur_n;
        logic             dir_n;
        logic             sel;

        assign sel   = cmd_acc && !ch_bad && (cmd_ch == CH_W'(i));
        assign cur_x = {1'b0, cur_q};
        assign tgt_x = {1'b0, tgt_q};

        // The move at a boundary follows the mode of the frame just ending.
        always_comb begin
            cur_n = cur_x;
            dir_n = dir_up_q;
            case (mode_q)
                MODE_TRACK: begin
                    if (tgt_x > cur_x)      cur_n = (tgt_x - cur_x > STEP_X) ? cur_x + STEP_X : tgt_x;
                    else if (tgt_x < cur_x) cur_n = (cur_x - tgt_x > STEP_X) ? cur_x - STEP_X : tgt_x;
                end
                MODE_SWEEP: begin
                    if (dir_up_q) begin
                        if (cur_x + STEP_X >= SPAN_X) begin
                            cur_n = SPAN_X;
                            dir_n = 1'b0;
                        end else begin
                            cur_n = cur_x + STEP_X;
                        end
                    end else begin
                        if (cur_x <= STEP_X) begin
                            cur_n = '0;
                            dir_n = 1'b1;
                        end else begin
                            cur_n = cur_x - STEP_X;
                        end
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mode_q   <= MODE_OFF;
                pend_q   <= MODE_OFF;
                cur_q    <= POS_W'(SPAN / 2);
                tgt_q    <= POS_W'(SPAN / 2);
                dir_up_q <= 1'b1;
                busy_q   <= 1'b0;
                servo_q  <= 1'b0;
            end else begin
                if (sel) begin
                    pend_q <= cmd_mode_m;
                    tgt_q  <= pos_cl;
                end
                if (boundary) begin
                    mode_q   <= pend_q;
                    cur_q    <= cur_n[POS_W-1:0];
                    dir_up_q <= dir_n;
                    busy_q   <= (pend_q == MODE_TRACK) && (cur_n != tgt_x);
                end
                servo_q <= (mode_q != MODE_OFF) && (32'(fcnt) < 32'(MIN_TICKS) + 32'(cur_q));
            end
        end

        assign servo[i] = servo_q;
        assign busy[i]  = busy_q;
    end

endmodule
